sad_search_ctrl: RTL and testbench

Full-search motion-estimation controller for the SAD datapath. It walks every candidate motion vector in a ±RANGE window and, for each one, fetches the BLK_W×BLK_W current/reference pixel pairs. It accumulates absolute differences through one shared 32-bit Kogge-Stone adder instance and keeps the minimum SAD and its vector. The same adder instance is time-shared between accumulation and best-SAD comparison; no second adder is instantiated.

---
 rtl/sad_pkg.sv | 16 +
 rtl/sad_search_ctrl_ks.sv | 52 +++++
 rtl/sad_search_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_sad_search_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sad_pkg.sv
// Shared types and defaults for the full-search SAD motion-estimation controller.
package sad_pkg;
  localparam int SAD_W     = 32;
  localparam int BLK_W_DEF = 4;
  localparam int RANGE_DEF = 2;
  localparam int PIX_W_DEF = 8;
  localparam int MV_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_CMP,
    ST_DONE
  } state_e;
endpackage

// File: rtl/sad_search_ctrl_ks.sv
// 32-bit Kogge-Stone parallel-prefix adder with carry-in and carry-out.
module KOGGESTONE32BIT (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);
  logic [31:0] half_sum;
  logic [31:0] grp_g;
  logic [31:0] grp_p;
  logic [32:0] carry;

  assign half_sum = a_i ^ b_i;

  // After five doubling levels grp_g/grp_p cover the whole span [i:0].
  always_comb begin
    logic [31:0] gk, pk, gn, pn;
    gk = a_i & b_i;
    pk = a_i ^ b_i;
    gn = gk;
    pn = pk;
    for (int lvl = 0; lvl < 5; lvl++) begin
      gn = gk;
      pn = pk;
      for (int i = 0; i < 32; i++) begin
        if (i >= (1 << lvl)) begin
          gn[i] = gk[i] | (pk[i] & gk[i - (1 << lvl)]);
          pn[i] = pk[i] & pk[i - (1 << lvl)];
        end
      end
      gk = gn;
      pk = pn;
    end
    grp_g = gk;
    grp_p = pk;
  end

  assign carry[0] = cin_i;

  genvar gi;
  generate
    for (gi = 1; gi <= 32; gi++) begin : g_carry
      assign carry[gi] = grp_g[gi-1] | (grp_p[gi-1] & cin_i);
    end
    for (gi = 0; gi < 32; gi++) begin : g_sum
      assign sum_o[gi] = half_sum[gi] ^ carry[gi];
    end
  endgenerate

  assign cout_o = carry[32];
endmodule

// File: rtl/sad_search_ctrl.sv
// Full-search motion-estimation controller: walks all candidate vectors, accumulates SAD
// through one shared adder and keeps the minimum SAD with its vector.
module sad_search_ctrl
  import sad_pkg::*;
#(
  parameter int BLK_W = BLK_W_DEF,
  parameter int RANGE = RANGE_DEF,
  parameter int PIX_W = PIX_W_DEF,
  parameter int MV_W  = MV_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  input  logic                       rd_rdy,
  output logic [$clog2(BLK_W)-1:0]   rd_px,
  output logic [$clog2(BLK_W)-1:0]   rd_py,
  output logic signed [MV_W-1:0]     rd_mvx,
  output logic signed [MV_W-1:0]     rd_mvy,
  input  logic [PIX_W-1:0]           cur_pix,
  input  logic [PIX_W-1:0]           ref_pix,
  output logic [SAD_W-1:0]           best_sad,
  output logic signed [MV_W-1:0]     best_mvx,
  output logic signed [MV_W-1:0]     best_mvy
);
  localparam int PXW  = $clog2(BLK_W);
  localparam int IDXW = 2 * PXW;
  localparam logic signed [MV_W-1:0] MV_MAX = MV_W'(RANGE);
  localparam logic signed [MV_W-1:0] MV_MIN = MV_W'(-RANGE);
  localparam logic signed [MV_W-1:0] MV_ONE = MV_W'(1);
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
  localparam logic [IDXW-1:0] IDX_LAST = '1;

  state_e                 state_q, state_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic signed [MV_W-1:0] mvx_q, mvx_d, mvy_q, mvy_d;
  logic [SAD_W-1:0]       acc_q, acc_d, best_q, best_d;
  logic signed [MV_W-1:0] bmvx_q, bmvx_d, bmvy_q, bmvy_d;
  logic [SAD_W-1:0]       osad_q, osad_d;
  logic signed [MV_W-1:0] omvx_q, omvx_d, omvy_q, omvy_d;
  logic                   rvld_q, rvld_d;

  logic [PIX_W:0]   diff, absdiff;
  logic [SAD_W-1:0] ks_b, ks_sum;
  logic             ks_cin, ks_cout, cand_lt;
  logic             last_pix, last_mv;

  assign diff    = {1'b0, cur_pix} - {1'b0, ref_pix};
  assign absdiff = diff[PIX_W] ? -diff : diff;

  // One adder: accumulate |cur-ref| while pixels stream, subtract best in CMP.
  always_comb begin
    ks_b   = {{(SAD_W-PIX_W-1){1'b0}}, absdiff};
    ks_cin = 1'b0;
    if (state_q == ST_CMP) begin
      ks_b   = ~best_q;
      ks_cin = 1'b1;
    end
  end

  KOGGESTONE32BIT u_ks (
    .a_i    (acc_q),
    .b_i    (ks_b),
    .cin_i  (ks_cin),
    .sum_o  (ks_sum),
    .cout_o (ks_cout)
  );

  // No carry out of acc - best means acc < best; equality keeps the earlier vector.
  assign cand_lt  = ~ks_cout;
  assign last_pix = (idx_q == IDX_LAST);
  assign last_mv  = (mvx_q == MV_MAX) && (mvy_q == MV_MAX);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mvx_d   = mvx_q;
    mvy_d   = mvy_q;
    acc_d   = acc_q;
    best_d  = best_q;
    bmvx_d  = bmvx_q;
    bmvy_d  = bmvy_q;
    osad_d  = osad_q;
    omvx_d  = omvx_q;
    omvy_d  = omvy_q;
    rvld_d  = (state_q == ST_RUN) && rd_rdy;

    if (rvld_q) begin
      acc_d = ks_sum;
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          idx_d   = '0;
          mvx_d   = MV_MIN;
          mvy_d   = MV_MIN;
          acc_d   = '0;
          best_d  = '1;
        end
      end
      ST_RUN: begin
        if (rd_rdy) begin
          idx_d = idx_q + IDX_ONE;
          if (last_pix) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_CMP;
      end
      ST_CMP: begin
        acc_d = '0;
        if (cand_lt) begin
          best_d = acc_q;
          bmvx_d = mvx_q;
          bmvy_d = mvy_q;
        end
        if (last_mv) begin
          state_d = ST_DONE;
          osad_d  = cand_lt ? acc_q : best_q;
          omvx_d  = cand_lt ? mvx_q : bmvx_q;
          omvy_d  = cand_lt ? mvy_q : bmvy_q;
        end else begin
          state_d = ST_RUN;
          if (mvx_q == MV_MAX) begin
            mvx_d = MV_MIN;
            mvy_d = mvy_q + MV_ONE;
          end else begin
            mvx_d = mvx_q + MV_ONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      mvx_q   <= '0;
      mvy_q   <= '0;
      acc_q   <= '0;
      best_q  <= '1;
      bmvx_q  <= '0;
      bmvy_q  <= '0;
      osad_q  <= '0;
      omvx_q  <= '0;
      omvy_q  <= '0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mvx_q   <= mvx_d;
      mvy_q   <= mvy_d;
      acc_q   <= acc_d;
      best_q  <= best_d;
      bmvx_q  <= bmvx_d;
      bmvy_q  <= bmvy_d;
      osad_q  <= osad_d;
      omvx_q  <= omvx_d;
      omvy_q  <= omvy_d;
      rvld_q  <= rvld_d;
    end
  end

  assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_CMP);
  assign done     = (state_q == ST_DONE);
  assign rd_en    = (state_q == ST_RUN);
  assign rd_px    = idx_q[PXW-1:0];
  assign rd_py    = idx_q[IDXW-1:PXW];
  assign rd_mvx   = mvx_q;
  assign rd_mvy   = mvy_q;
  assign best_sad = osad_q;
  assign best_mvx = omvx_q;
  assign best_mvy = omvy_q;
endmodule

// File: tb/tb_sad_search_ctrl.sv
// Self-checking bench: pixel-memory responder, reference full-search model, per-cycle compare.
module tb_sad_search_ctrl;
  logic              clk = 1'b0;
  logic              rst, start, rd_rdy;
  logic              busy, done, rd_en;
  logic [1:0]        rd_px, rd_py;
  logic signed [7:0] rd_mvx, rd_mvy;
  logic [7:0]        cur_pix, ref_pix;
  logic [31:0]       best_sad;
  logic signed [7:0] best_mvx, best_mvy;

  sad_search_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_rdy(rd_rdy), .rd_px(rd_px), .rd_py(rd_py),
    .rd_mvx(rd_mvx), .rd_mvy(rd_mvy), .cur_pix(cur_pix), .ref_pix(ref_pix),
    .best_sad(best_sad), .best_mvx(best_mvx), .best_mvy(best_mvy)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;
  int mode = 0, t0 = 0, stalls = 0, accepts = 0;
  bit bp = 0, active = 0, done_seen = 0, post_rst = 0, prev_stall = 0;
  int ref_sad = 0, ref_mvx = 0, ref_mvy = 0;
  longint exp_sad_o = 0, exp_mvx_o = 0, exp_mvy_o = 0;
  logic [1:0] prev_px, prev_py;
  logic signed [7:0] prev_mvx, prev_mvy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, $signed(act), $signed(exp), cyc);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int cur_f(input int m, input int mx, input int my, input int px, input int py);
    case (m)
      0: return 7;
      3: return 255;
      4: return (px * 37 + py * 11 + 5) % 256;
      default: return 100;
    endcase
  endfunction

  function automatic int ref_f(input int m, input int mx, input int my, input int px, input int py);
    case (m)
      0: return 7;
      3: return 0;
      4: return (px * 13 + py * 29 + mx * 17 + my * 7 + 100) % 256;
      default: return 100 + 3 * (iabs(mx - 1) + iabs(my + 1));
    endcase
  endfunction

  function automatic int sad_of(input int m, input int mx, input int my);
    int s = 0;
    for (int py = 0; py < 4; py++)
      for (int px = 0; px < 4; px++)
        s += iabs(cur_f(m, mx, my, px, py) - ref_f(m, mx, my, px, py));
    return s;
  endfunction

  // Reference search: scan in raster order, strict less-than keeps the earliest tie.
  task automatic compute_expected(input int m);
    int s;
    ref_sad = 32'h7FFF_FFFF;
    for (int my = -2; my <= 2; my++)
      for (int mx = -2; mx <= 2; mx++) begin
        s = sad_of(m, mx, my);
        if (s < ref_sad) begin
          ref_sad = s; ref_mvx = mx; ref_mvy = my;
        end
      end
  endtask

  // Memory responder: data for an accepted request appears one cycle later; otherwise garbage.
  always @(posedge clk) begin
    bit acc;
    int px, py, mx, my;
    acc = rd_en && rd_rdy;
    px = rd_px; py = rd_py; mx = rd_mvx; my = rd_mvy;
    #1;
    if (acc) begin
      cur_pix = 8'(cur_f(mode, mx, my, px, py));
      ref_pix = 8'(ref_f(mode, mx, my, px, py));
    end else begin
      cur_pix = 8'($urandom);
      ref_pix = 8'($urandom);
    end
    rd_rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    int k;
    if (rst) begin
      active = 0; post_rst = 1; prev_stall = 0;
      exp_sad_o = 0; exp_mvx_o = 0; exp_mvy_o = 0;
    end else begin
      if (post_rst) begin
        chk("reset_ctrl", {busy, done, rd_en}, 0);
        chk("reset_rdaddr", {rd_px, rd_py, rd_mvx, rd_mvy}, 0);
        post_rst = 0;
      end
      if (prev_stall) begin
        chk("stall_rd_en", rd_en, 1);
        chk("stall_stable", {rd_px, rd_py, rd_mvx, rd_mvy}, {prev_px, prev_py, prev_mvx, prev_mvy});
      end
      if (active) begin
        k = cyc - t0;
        if (k == 0) begin
          chk("busy_start_cycle", {busy, done}, 0);
        end else if (cyc < t0 + 451 + stalls) begin
          chk("busy_run", {busy, done}, 2'b10);
        end else begin
          chk("done_pulse", {busy, done}, 2'b01);
          chk("best_sad", best_sad, ref_sad);
          chk("best_mvx", best_mvx, ref_mvx);
          chk("best_mvy", best_mvy, ref_mvy);
          chk("accept_count", accepts, 400);
          if (!bp) chk("done_latency", k, 451);
          exp_sad_o = ref_sad; exp_mvx_o = ref_mvx; exp_mvy_o = ref_mvy;
          active = 0; done_seen = 1;
        end
        if (rd_en && !rd_rdy) stalls++;
        if (rd_en && rd_rdy) accepts++;
        if (active && k > 3000) begin
          tests++; fails++;
          $display("FAIL timeout: no done after %0d cycles, required by %0d", k, 451 + stalls);
          active = 0; done_seen = 1;
        end
      end else begin
        chk("idle_ctrl", {busy, done, rd_en}, 0);
      end
      chk("hold_sad", best_sad, exp_sad_o);
      chk("hold_mv", {best_mvx, best_mvy}, {8'(exp_mvx_o), 8'(exp_mvy_o)});
      prev_stall = rd_en && !rd_rdy;
      prev_px = rd_px; prev_py = rd_py; prev_mvx = rd_mvx; prev_mvy = rd_mvy;
    end
  end

  task automatic run_search(input int m, input bit use_bp, input int rst_at);
    bit finished = 0;
    mode = m; bp = use_bp;
    compute_expected(m);
    @(posedge clk); #1;
    start = 1'b1; t0 = cyc; stalls = 0; accepts = 0; done_seen = 0; active = 1;
    for (int k = 1; k < 4000; k++) begin
      @(posedge clk); #1;
      start = (k == 40 || k == 260);
      rst   = (rst_at != 0 && k == rst_at);
      if (rst_at != 0 && k == rst_at + 1) begin finished = 1; break; end
      if (done_seen) begin finished = 1; break; end
      if (done) start = 1'b1;
    end
    start = 1'b0;
    if (!finished) begin
      tests++; fails++;
      $display("FAIL search_end: mode %0d never completed, required completion", m);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rd_rdy = 1'b1; cur_pix = '0; ref_pix = '0;
    chk("model_sad_umin_corner", sad_of(1, -2, -2), 192);
    chk("model_sad_second_best", sad_of(1, 0, -1), 48);
    chk("model_sad_max", sad_of(3, 0, 0), 4080);
    compute_expected(1);
    chk("model_umin", {32'(ref_sad), 16'(ref_mvx), 16'(ref_mvy)}, {32'd0, 16'd1, -16'sd1});
    compute_expected(0);
    chk("model_tie", {32'(ref_sad), 16'(ref_mvx), 16'(ref_mvy)}, {32'd0, -16'sd2, -16'sd2});
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    run_search(0, 0, 0);
    $display("[TB] uniform: sad=%0d mv=(%0d,%0d)", best_sad, best_mvx, best_mvy);
    run_search(1, 0, 0);
    $display("[TB] unique min: sad=%0d mv=(%0d,%0d)", best_sad, best_mvx, best_mvy);
    run_search(1, 1, 0);
    $display("[TB] backpressure: sad=%0d mv=(%0d,%0d) stalls=%0d", best_sad, best_mvx, best_mvy, stalls);
    run_search(3, 0, 0);
    $display("[TB] max sad: sad=%0d mv=(%0d,%0d)", best_sad, best_mvx, best_mvy);
    run_search(4, 1, 0);
    $display("[TB] mixed pixels: sad=%0d mv=(%0d,%0d)", best_sad, best_mvx, best_mvy);
    run_search(1, 0, 200);
    $display("[TB] reset mid-search: sad=%0d busy=%0d", best_sad, busy);
    run_search(1, 0, 0);
    $display("[TB] after reset: sad=%0d mv=(%0d,%0d)", best_sad, best_mvx, best_mvy);
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
